// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a five-stage RISC-V pipeline: load-use bubbles, branch squash, data-memory wait with timeout.
// Optional stall-cycle counter is built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_br_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_busy,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [TW-1:0]   tmo_r, tmo_nx_s, tmo_inc_s;
    logic            err_r, err_nx_s;
    logic            load_use_s, mem_stall_s, release_s;

    // Hazard detection terms
    always_comb begin
        load_use_s  = ex_is_load && (ex_rd != {REG_ADDR_W{1'b0}}) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        mem_stall_s = mem_req && !mem_ack;
        tmo_inc_s   = tmo_r + TW'(1);
        // A WAIT released by ack behaves exactly like an unstalled RUN cycle
        release_s   = ((state_r == ST_RUN) && !mem_stall_s) ||
                      ((state_r == ST_WAIT) && mem_ack);
    end

    // Pipeline register enables and flushes, same-cycle from state and hazards
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state_r == ST_ABORT) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
            ex_mem_flush = 1'b1;
        end else if (release_s) begin
            if (ex_br_taken) begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_s) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
            end
        end else begin
            pc_en = 1'b0;
        end
    end

    // Next-state, timeout counter and sticky error
    always_comb begin
        state_nx_s = state_r;
        tmo_nx_s   = tmo_r;
        err_nx_s   = err_r;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_nx_s = ST_WAIT;
                    tmo_nx_s   = TW'(1);
                end else begin
                    tmo_nx_s   = {TW{1'b0}};
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_nx_s = ST_RUN;
                    tmo_nx_s   = {TW{1'b0}};
                end else if (tmo_inc_s == TW'(MEM_TIMEOUT)) begin
                    state_nx_s = ST_ABORT;
                    tmo_nx_s   = {TW{1'b0}};
                    err_nx_s   = 1'b1;
                end else begin
                    tmo_nx_s   = tmo_inc_s;
                end
            end
            ST_ABORT: begin
                state_nx_s = ST_RUN;
                tmo_nx_s   = {TW{1'b0}};
            end
            default: begin
                state_nx_s = ST_RUN;
                tmo_nx_s   = {TW{1'b0}};
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            tmo_r   <= {TW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            tmo_r   <= tmo_nx_s;
            err_r   <= err_nx_s;
        end
    end

    assign mem_busy = (state_r == ST_WAIT) && !rst;
    assign mem_err  = err_r && !rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles with the PC frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = rst ? {CNT_W{1'b0}} : stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
